// File: rtl/wb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Optional watchdog is enabled with WB_ARB_TIMEOUT_EN.
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_arbiter_2m_pick.sv
// Two-input round-robin picker: on a tie the master that did not
// own the bus last wins. last=1 means master 1 owned it last.
module wb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone classic arbiter, cyc-framed RR grant.
// Define WB_ARB_TIMEOUT_EN to add the hung-slave watchdog (ABORT).
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_dat_w,
  output logic [DW-1:0] m0_dat_r,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_dat_w,
  output logic [DW-1:0] m1_dat_r,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_dat_w,
  input  logic [DW-1:0] s_dat_r,
  input  logic          s_ack,
  output logic [1:0]    grant
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT out of range");
  end

  arb_state_t state;
  logic       last;
  logic [1:0] win;
  logic       busy;
  logic       own_cyc;
  logic       hit;

  wb_rr_pick u_pick (
    .req  ({m1_cyc, m0_cyc}),
    .last (last),
    .win  (win)
  );

  assign busy    = (state == BUSY);
  assign own_cyc = (grant[0] & m0_cyc) | (grant[1] & m1_cyc);

  // Pure passthrough of the owner; everything reads 0 when not BUSY.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_dat_w = '0;
    unique case (1'b1)
      busy & grant[0]: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
        s_we    = m0_we;
        s_addr  = m0_addr;
        s_dat_w = m0_dat_w;
      end
      busy & grant[1]: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
        s_we    = m1_we;
        s_addr  = m1_addr;
        s_dat_w = m1_dat_w;
      end
      default: ;
    endcase
  end

  assign m0_ack   = s_ack & busy & grant[0];
  assign m1_ack   = s_ack & busy & grant[1];
  assign m0_dat_r = grant[0] ? s_dat_r : '0;
  assign m1_dat_r = grant[1] ? s_dat_r : '0;

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  logic [1:0]  err_q;
  logic        hung;

  assign hung = busy & s_cyc & ~s_ack;
  assign hit  = hung & (({1'b0, cnt} + 17'd1) == 17'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 2'b00;
    end else begin
      err_q <= hit ? grant : 2'b00;
      if (!busy || s_ack)
        cnt <= '0;
      else if (hung)
        cnt <= cnt + 16'd1;
    end
  end

  assign m0_err = err_q[0];
  assign m1_err = err_q[1];
`else
  assign hit    = 1'b0;
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (|win) begin
            grant <= win;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!own_cyc) begin
            state <= IDLE;
            grant <= 2'b00;
            last  <= grant[1];
          end else if (hit) begin
            state <= ABORT;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        ABORT: begin
          if (!own_cyc) begin
            state <= IDLE;
            grant <= 2'b00;
            last  <= grant[1];
          end
        end
`endif
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule
